rr_sel_arbiter: RTL

//   Round-robin channel arbiter that drives the select input of the 4:1

---
 rtl/rr_sel_arbiter_if.sv | 17 +
 rtl/rr_sel_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/rr_sel_arbiter_if.sv
// Request/grant bundle between the requesters and rr_sel_arbiter.
// The lock signal exists only when RR_LOCK_EN is defined.
interface rr_sel_arbiter_if;
    logic [3:0] req;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
`ifdef RR_LOCK_EN
    logic       lock;

    modport slave  (input  req, input  lock, output sel, output grant, output busy);
    modport master (output req, output lock, input  sel, input  grant, input  busy);
`else
    modport slave  (input  req, output sel, output grant, output busy);
    modport master (output req, input  sel, input  grant, input  busy);
`endif
endinterface

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter steering the select of a downstream 4:1 mux, with a dwell
// timeout and a one-cycle guard gap. Optional grant lock: define RR_LOCK_EN.
module rr_sel_arbiter #(
    parameter int DWELL = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    rr_sel_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       grant_q, grant_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;

    logic             anyReq;
    logic [1:0]       winner;
    logic             lockActive;
    logic             atLimit;
    logic             grantDone;

`ifdef RR_LOCK_EN
    assign lockActive = bus.lock;
`else
    assign lockActive = 1'b0;
`endif

    assign anyReq    = |bus.req;
    assign atLimit   = (cnt_q == LAST);
    // A held lock only suppresses the timeout; a dropped request always ends the grant.
    assign grantDone = !bus.req[sel_q] || (atLimit && !lockActive);

    always_comb begin
        logic [1:0] idx;
        logic       found;
        winner = ptr_q;
        found  = 1'b0;
        idx    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'b00;
            grant_q <= 4'b0000;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (anyReq) state_d = GRANT;
            GRANT:   if (grantDone) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // sel is only reloaded when leaving IDLE, so it is stable for the whole grant.
    always_comb begin
        sel_d   = sel_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    sel_d   = winner;
                    grant_d = 4'b0001 << winner;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                end
            end
            GRANT: begin
                if (grantDone) begin
                    grant_d = 4'b0000;
                    busy_d  = 1'b1;
                    ptr_d   = sel_q + 2'd1;
                end else if (!atLimit) begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            GAP: begin
                grant_d = 4'b0000;
                busy_d  = 1'b0;
            end
            default: begin
                grant_d = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.sel   = sel_q;
    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;

endmodule
